// File: rtl/decimating_frame_buffer.sv
// decimating_frame_buffer
// Mixes filtered stereo samples to mono, keeps one of every DECIM samples, and
// captures one frame of DEPTH samples per start pulse into on-chip RAM.
// The frame is read back through a registered random-access port with
// read-before-write behaviour on address collisions.
module decimating_frame_buffer #(
    parameter int DATA_SIZE = 24,
    parameter int DECIM     = 4,
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATA_SIZE-1:0] in_left,
    input  logic signed [DATA_SIZE-1:0] in_right,
    input  logic                        in_ready,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic signed [DATA_SIZE-1:0] rd_data,
    output logic                        rd_valid
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [ADDR_W-1:0]           wr_ptr;
    logic [CNT_W-1:0]            decim_cnt;
    logic signed [DATA_SIZE:0]   sum;
    logic signed [DATA_SIZE-1:0] mono;
    logic                        wr_en;
    logic                        last_write;
    logic                        start_ok;
    logic signed [DATA_SIZE-1:0] mem [DEPTH];

    // Widen by one bit before adding so the sum cannot overflow; the
    // arithmetic shift halves it rounding toward minus infinity.
    assign sum  = (DATA_SIZE+1)'(in_left) + (DATA_SIZE+1)'(in_right);
    assign mono = DATA_SIZE'(sum >>> 1);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential logic uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start leaves IDLE/DONE, the final write ends the capture.
    always_comb begin
        // NOTE: the default assignment first means every path drives state_next, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE, DONE: if (start)      state_next = CAPTURE;
            CAPTURE:    if (last_write) state_next = DONE;
            default:                    state_next = IDLE;
        endcase
    end

    // Output and control decode from the registered state.
    always_comb begin
        busy       = (state == CAPTURE);
        frame_done = (state == DONE);
        start_ok   = (state != CAPTURE) && start;
        wr_en      = rst && (state == CAPTURE) && in_ready && (decim_cnt == '0);
        last_write = wr_en && (wr_ptr == ADDR_W'(DEPTH - 1));
    end

    // Write pointer and decimation phase; both restart on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            decim_cnt <= '0;
        end else if (start_ok) begin
            wr_ptr    <= '0;
            decim_cnt <= '0;
        end else if ((state == CAPTURE) && in_ready) begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            decim_cnt <= (decim_cnt == CNT_W'(DECIM - 1)) ? '0 : decim_cnt + CNT_W'(1);
        end
    end

    // Frame RAM write port.
    // NOTE: the RAM array has no reset so it can map onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= mono;
        end
    end

    // Registered read port; reading the array here returns pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule
